// File: rtl/oparb.sv
// Round-robin arbiter for one output port of the mesh router.
// Five input controllers (PE, S, N, E, W) compete for the port. Even and odd
// virtual channels each keep their own priority pointer and a saturating
// count of accepted grants. The grant is combinational because the output
// controller samples it in the same cycle it is issued.
module oparb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic [4:0]       req,
    input  logic             empty,
    output logic [4:0]       grant,
    output logic             grant_valid,
    output logic [2:0]       ptr_even,
    output logic [2:0]       ptr_odd,
    output logic [CNT_W-1:0] grant_cnt_even,
    output logic [CNT_W-1:0] grant_cnt_odd
);

    // Reduce a value in 0..8 to 0..4. Pointers never exceed 4, so sums never exceed 8.
    function automatic logic [2:0] mod5(input logic [3:0] v);
        logic [3:0] t;
        t = (v >= 4'd5) ? (v - 4'd5) : v;
        return t[2:0];
    endfunction

    logic [2:0]       ptr_even_q, ptr_even_d;
    logic [2:0]       ptr_odd_q, ptr_odd_d;
    logic [CNT_W-1:0] cnt_even_q, cnt_even_d;
    logic [CNT_W-1:0] cnt_odd_q, cnt_odd_d;

    logic [2:0] active_ptr;
    logic [2:0] cand_idx [5];
    logic       found;
    logic [2:0] win_idx;
    logic       accept;

    // Select the pointer of the channel being served this cycle.
    always_comb begin
        active_ptr = polarity ? ptr_odd_q : ptr_even_q;
    end

    // Candidate input index for each search position, starting at the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cand
            assign cand_idx[gi] = mod5({1'b0, active_ptr} + 4'(gi));
        end
    endgenerate

    // Walk the search order from the far end back, so the nearest requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                found   = 1'b1;
                win_idx = cand_idx[k];
            end
        end
    end

    // A transfer happens only with a requester, buffer space and no reset.
    always_comb begin
        accept      = found & empty & ~reset;
        grant       = accept ? (5'b00001 << win_idx) : 5'b00000;
        grant_valid = accept;
    end

    // Advance the active channel's pointer past the winner and bump its counter.
    always_comb begin
        ptr_even_d = ptr_even_q;
        ptr_odd_d  = ptr_odd_q;
        cnt_even_d = cnt_even_q;
        cnt_odd_d  = cnt_odd_q;
        if (accept) begin
            if (polarity) begin
                ptr_odd_d = mod5({1'b0, win_idx} + 4'd1);
                if (cnt_odd_q != {CNT_W{1'b1}}) begin
                    cnt_odd_d = cnt_odd_q + 1'b1;
                end
            end else begin
                ptr_even_d = mod5({1'b0, win_idx} + 4'd1);
                if (cnt_even_q != {CNT_W{1'b1}}) begin
                    cnt_even_d = cnt_even_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_even_q <= 3'd0;
            ptr_odd_q  <= 3'd0;
            cnt_even_q <= '0;
            cnt_odd_q  <= '0;
        end else begin
            ptr_even_q <= ptr_even_d;
            ptr_odd_q  <= ptr_odd_d;
            cnt_even_q <= cnt_even_d;
            cnt_odd_q  <= cnt_odd_d;
        end
    end

    assign ptr_even       = ptr_even_q;
    assign ptr_odd        = ptr_odd_q;
    assign grant_cnt_even = cnt_even_q;
    assign grant_cnt_odd  = cnt_odd_q;

endmodule

// File: doc/oparb.md
Name: oparb

Overview:
- Per-output-port round-robin arbiter for the mesh router. It drives the 5-bit one-hot grant into the output-port controller for the same port.
- It chooses among the five input controllers (PE, S, N, E, W) that request this output port.
- Even and odd virtual channels (selected by polarity) keep independent round-robin pointers, so fairness holds separately per channel.
- It also keeps saturating per-channel grant counters for performance monitoring.

Parameters:
CNT_W, 16, width of each saturating grant counter (legal 4..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
polarity  input  1  0 = even cycle/channel, 1 = odd cycle/channel
req  input  5  request vector; bit0=PE, bit1=S, bit2=N, bit3=E, bit4=W
empty  input  1  high when the output controller's buffer for the current polarity can accept a flit
grant  output  5  one-hot grant to the output controller (all-zero = no grant)
grant_valid  output  1  OR of grant; high exactly when a transfer is accepted this cycle
ptr_even  output  3  current even-channel priority pointer (0..4)
ptr_odd  output  3  current odd-channel priority pointer (0..4)
grant_cnt_even  output  CNT_W  number of accepted even-channel grants, saturating
grant_cnt_odd  output  CNT_W  number of accepted odd-channel grants, saturating

Behaviour:
- Registered state:
  - ptr_even and ptr_odd, each 3 bits, holding values 0..4 only.
  - grant_cnt_even and grant_cnt_odd.
- Reset (reset high at a clk edge):
  - Both pointers become 0 and both counters become 0.
  - While reset is high, grant = 5'b00000 and grant_valid = 0, regardless of req and empty.
- Grant generation is combinational with zero-cycle latency, because the output controller samples grant in the same cycle.
  - Active pointer P = ptr_even when polarity = 0, otherwise ptr_odd.
  - Search order is P, P+1, ..., P+4, each taken mod 5. The first index with req set is granted.
  - grant = one-hot of the winner when empty = 1 and req != 0; otherwise grant = 0.
  - grant is never non-one-hot. Indices 5..7 are never generated.
- Acceptance: a grant is accepted on any cycle with grant_valid = 1. At the next clk edge:
  - The active-polarity pointer becomes (winner + 1) mod 5. The winner 4 (W) wraps to 0 (PE).
  - The inactive-polarity pointer holds.
  - The active-polarity counter increments by 1. If it is already all-ones it holds (saturates, no wrap).
  - The inactive-polarity counter holds.
- No acceptance (empty = 0, or req = 0): both pointers and both counters hold.
  - A request with empty = 0 is not granted. Pointer priority is not consumed.
- Requests are level signals. A requester keeps req high until it sees its own grant bit. The arbiter does not latch requests.
- A requester that drops req before being granted loses no priority state; the pointer is unaffected.
- Fairness: with all five requesting continuously and empty = 1, each polarity grants in the order PE, S, N, E, W, PE, ...
  - Any continuously requesting input is granted within 5 accepted grants of its polarity.
- Polarity toggling every cycle interleaves the two independent sequences; neither pointer advances on the other's cycles.
- Reset asserted mid-operation: the same-cycle grant is forced to 0 and no transfer occurs. State returns to the reset values at that edge.
- Pure sequential plus combinational; no latches. All outputs are defined from the first post-reset cycle.

Test Plan:
1. Reset, then polarity = 0, empty = 1, req = 5'b11111 held for 6 cycles -> grant = 00001, 00010, 00100, 01000, 10000, 00001; ptr_even = 1, 2, 3, 4, 0, 1 after each edge; grant_cnt_even = 6; ptr_odd = 0 and grant_cnt_odd = 0 throughout.
2. Polarity toggling every cycle, req = 5'b10100, empty = 1 -> even cycles grant 00100, 10000, 00100; odd cycles independently grant 00100, 10000, 00100; each pointer alternates 3 -> 0 -> 3.
3. empty = 0 with req = 5'b00011 for 3 cycles -> grant = 0, grant_valid = 0, pointers and counters unchanged. Then empty = 1 -> grant = 00001 (pointer still 0).
4. Start from ptr_even = 4 (reached by granting N, then E), req = 5'b00001 -> wrap search grants PE (00001); ptr_even becomes 1.
5. CNT_W = 4, continuous even acceptance for 20 cycles -> grant_cnt_even reaches 15 at cycle 15 and stays 15; grant keeps rotating.
6. reset asserted during active granting with req = 5'b11111 -> grant = 0 in the reset cycle; next cycle (reset low) grant = 00001, pointers = 0, counters = 0.
